// File: rtl/phyretrain_sb_ctrl.sv
// PHYRETRAIN substate sequencer: enables TX/RX sub-FSMs, round-robin shares the SB port, tracks done/timeout.
// Optional PHYRETRAIN_SB_STATS_EN adds saturating per-requester sent-message counters.
module phyretrain_sb_ctrl #(
    parameter int unsigned SB_MSG_WIDTH   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 8000,
    parameter int unsigned CNT_W          = 24
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_phyretrain_en,
    input  logic                    i_tx_valid,
    input  logic [SB_MSG_WIDTH-1:0] i_tx_msg,
    input  logic [2:0]              i_tx_info,
    input  logic                    i_tx_end,
    input  logic                    i_rx_valid,
    input  logic [SB_MSG_WIDTH-1:0] i_rx_msg,
    input  logic [2:0]              i_rx_info,
    input  logic                    i_rx_end,
    input  logic                    i_sb_busy,
    output logic                    o_sub_en,
    output logic                    o_sb_valid,
    output logic [SB_MSG_WIDTH-1:0] o_sb_msg,
    output logic [2:0]              o_sb_info,
    output logic                    o_tx_sent,
    output logic                    o_rx_sent,
    output logic                    o_phyretrain_done,
    output logic                    o_timeout_err
`ifdef PHYRETRAIN_SB_STATS_EN
    ,
    output logic [7:0]              o_tx_msg_cnt,
    output logic [7:0]              o_rx_msg_cnt
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DONE, ST_ERROR} top_state_e;
    typedef enum logic [1:0] {ARB_IDLE, ARB_WAIT_HI, ARB_WAIT_LO, ARB_COOL} arb_state_e;
    typedef enum logic {GRANT_TX, GRANT_RX} grant_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    top_state_e              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    tx_end_q, tx_end_d;
    logic                    rx_end_q, rx_end_d;

    arb_state_e              arb_q, arb_d;
    grant_e                  last_q, last_d;
    logic                    valid_q, valid_d;
    logic [SB_MSG_WIDTH-1:0] msg_q, msg_d;
    logic [2:0]              info_q, info_d;
    logic                    tx_sent_q, tx_sent_d;
    logic                    rx_sent_q, rx_sent_d;
    logic                    busy_q;
    logic                    arb_run;
    logic                    pick_tx, pick_rx;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            tx_end_q  <= 1'b0;
            rx_end_q  <= 1'b0;
            arb_q     <= ARB_IDLE;
            last_q    <= GRANT_RX;
            valid_q   <= 1'b0;
            msg_q     <= '0;
            info_q    <= '0;
            tx_sent_q <= 1'b0;
            rx_sent_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tx_end_q  <= tx_end_d;
            rx_end_q  <= rx_end_d;
            arb_q     <= arb_d;
            last_q    <= last_d;
            valid_q   <= valid_d;
            msg_q     <= msg_d;
            info_q    <= info_d;
            tx_sent_q <= tx_sent_d;
            rx_sent_q <= rx_sent_d;
            busy_q    <= i_sb_busy;
        end
    end

    // Done is judged on the latched flags, so it takes priority over a coincident timeout.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tx_end_d = tx_end_q;
        rx_end_d = rx_end_q;
        if (!i_phyretrain_en) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            tx_end_d = 1'b0;
            rx_end_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = ST_ACTIVE;
                ST_ACTIVE: begin
                    cnt_d    = cnt_q + CNT_W'(1);
                    tx_end_d = tx_end_q | i_tx_end;
                    rx_end_d = rx_end_q | i_rx_end;
                    if (tx_end_q && rx_end_q) begin
                        state_d = ST_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_ERROR;
                    end
                end
                default:   state_d = state_q;
            endcase
        end
    end

    assign arb_run = i_phyretrain_en && ((state_q == ST_ACTIVE) || (state_q == ST_DONE));
    assign pick_tx = i_tx_valid && (!i_rx_valid || (last_q == GRANT_RX));
    assign pick_rx = i_rx_valid && (!i_tx_valid || (last_q == GRANT_TX));

    always_comb begin
        arb_d     = arb_q;
        last_d    = last_q;
        valid_d   = valid_q;
        msg_d     = msg_q;
        info_d    = info_q;
        tx_sent_d = 1'b0;
        rx_sent_d = 1'b0;
        if (!arb_run) begin
            arb_d   = ARB_IDLE;
            valid_d = 1'b0;
        end else begin
            case (arb_q)
                ARB_IDLE: begin
                    if (pick_tx) begin
                        msg_d   = i_tx_msg;
                        info_d  = i_tx_info;
                        valid_d = 1'b1;
                        last_d  = GRANT_TX;
                        arb_d   = ARB_WAIT_HI;
                    end else if (pick_rx) begin
                        msg_d   = i_rx_msg;
                        info_d  = i_rx_info;
                        valid_d = 1'b1;
                        last_d  = GRANT_RX;
                        arb_d   = ARB_WAIT_HI;
                    end
                end
                ARB_WAIT_HI: begin
                    if (i_sb_busy) arb_d = ARB_WAIT_LO;
                end
                ARB_WAIT_LO: begin
                    if (busy_q && !i_sb_busy) begin
                        valid_d   = 1'b0;
                        tx_sent_d = (last_q == GRANT_TX);
                        rx_sent_d = (last_q == GRANT_RX);
                        arb_d     = ARB_COOL;
                    end
                end
                default: arb_d = ARB_IDLE;
            endcase
        end
    end

    assign o_sub_en          = (state_q == ST_ACTIVE) || (state_q == ST_DONE);
    assign o_phyretrain_done = (state_q == ST_DONE);
    assign o_timeout_err     = (state_q == ST_ERROR);
    assign o_sb_valid        = valid_q;
    assign o_sb_msg          = msg_q;
    assign o_sb_info         = info_q;
    assign o_tx_sent         = tx_sent_q;
    assign o_rx_sent         = rx_sent_q;

`ifdef PHYRETRAIN_SB_STATS_EN
    logic [7:0] tx_cnt_q, rx_cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
        end else if (!i_phyretrain_en) begin
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (tx_sent_q && (tx_cnt_q != '1)) tx_cnt_q <= tx_cnt_q + 8'd1;
            if (rx_sent_q && (rx_cnt_q != '1)) rx_cnt_q <= rx_cnt_q + 8'd1;
        end
    end

    assign o_tx_msg_cnt = tx_cnt_q;
    assign o_rx_msg_cnt = rx_cnt_q;
`endif

endmodule

// File: tb/tb_phyretrain_sb_ctrl.sv
// Directed bench for phyretrain_sb_ctrl: arbitration, handshake, done/timeout, abort and optional stats.
module tb_phyretrain_sb_ctrl;

    localparam int unsigned MW = 4;
    localparam int unsigned TO = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          tx_valid, rx_valid, tx_end, rx_end, busy;
    logic [MW-1:0] tx_msg, rx_msg;
    logic [2:0]    tx_info, rx_info;
    logic          sub_en, sb_valid, tx_sent, rx_sent, done, err;
    logic [MW-1:0] sb_msg;
    logic [2:0]    sb_info;
`ifdef PHYRETRAIN_SB_STATS_EN
    logic [7:0]    tx_cnt, rx_cnt;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    phyretrain_sb_ctrl #(
        .SB_MSG_WIDTH  (MW),
        .TIMEOUT_CYCLES(TO),
        .CNT_W         (24)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_phyretrain_en  (en),
        .i_tx_valid       (tx_valid),
        .i_tx_msg         (tx_msg),
        .i_tx_info        (tx_info),
        .i_tx_end         (tx_end),
        .i_rx_valid       (rx_valid),
        .i_rx_msg         (rx_msg),
        .i_rx_info        (rx_info),
        .i_rx_end         (rx_end),
        .i_sb_busy        (busy),
        .o_sub_en         (sub_en),
        .o_sb_valid       (sb_valid),
        .o_sb_msg         (sb_msg),
        .o_sb_info        (sb_info),
        .o_tx_sent        (tx_sent),
        .o_rx_sent        (rx_sent),
        .o_phyretrain_done(done),
        .o_timeout_err    (err)
`ifdef PHYRETRAIN_SB_STATS_EN
        ,
        .o_tx_msg_cnt     (tx_cnt),
        .o_rx_msg_cnt     (rx_cnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are observed on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        en = 0; tx_valid = 0; rx_valid = 0; tx_end = 0; rx_end = 0; busy = 0;
        tx_msg = '0; rx_msg = '0; tx_info = '0; rx_info = '0;
        do_reset();
        check_eq("rst_sub_en", 32'(sub_en), 0);
        check_eq("rst_valid",  32'(sb_valid), 0);
        check_eq("rst_msg",    32'(sb_msg), 0);
        check_eq("rst_sent",   32'({tx_sent, rx_sent}), 0);
        check_eq("rst_done_err", 32'({done, err}), 0);

        // Single TX message through the busy handshake
        en = 1; step();
        check_eq("en_sub_en", 32'(sub_en), 1);
        tx_valid = 1; tx_msg = 4'd1; tx_info = 3'b001; step();
        check_eq("t1_valid", 32'(sb_valid), 1);
        check_eq("t1_msg",   32'(sb_msg), 1);
        check_eq("t1_info",  32'(sb_info), 1);
        busy = 1; tx_msg = 4'd7; step(); step(); step();
        check_eq("t1_valid_busy", 32'(sb_valid), 1);
        check_eq("t1_msg_hold",   32'(sb_msg), 1);
        check_eq("t1_no_early_sent", 32'(tx_sent), 0);
        busy = 0; step();
        check_eq("t1_valid_fall", 32'(sb_valid), 0);
        check_eq("t1_tx_sent",    32'({tx_sent, rx_sent}), 32'b10);
        tx_valid = 0; step();
        check_eq("t1_pulse_end",  32'(tx_sent), 0);

        // Ties: TX first after reset, then alternation
        en = 0; do_reset(); en = 1; step();
        tx_valid = 1; tx_msg = 4'd1; tx_info = 3'b001;
        rx_valid = 1; rx_msg = 4'd2; rx_info = 3'b010; step();
        check_eq("tie1_msg", 32'(sb_msg), 1);
        busy = 1; step(); busy = 0; step();
        check_eq("tie1_sent", 32'({tx_sent, rx_sent}), 32'b10);
        tx_msg = 4'd3; step();
        check_eq("tie_cool_valid", 32'(sb_valid), 0);
        check_eq("tie_cool_pulse", 32'(tx_sent), 0);
        step();
        check_eq("tie2_valid", 32'(sb_valid), 1);
        check_eq("tie2_msg",   32'(sb_msg), 2);
        check_eq("tie2_info",  32'(sb_info), 2);
        busy = 1; step(); busy = 0; step();
        check_eq("tie2_sent", 32'({tx_sent, rx_sent}), 32'b01);
        rx_valid = 0; step(); step();
        check_eq("tie3_msg", 32'(sb_msg), 3);
        busy = 1; step(); busy = 0; step();
        check_eq("tie3_sent", 32'({tx_sent, rx_sent}), 32'b10);
        tx_valid = 0; step();

        // Ends at different times, then together
        en = 0; step(); en = 1; step();
        repeat (8) step();
        tx_end = 1; step(); tx_end = 0;
        repeat (9) step();
        rx_end = 1; step(); rx_end = 0;
        check_eq("done_lat1", 32'(done), 0);
        step();
        check_eq("done_sep", 32'(done), 1);
        check_eq("done_sub_en", 32'(sub_en), 1);
        en = 0; step();
        check_eq("done_clear", 32'({done, sub_en}), 0);
        en = 1; step();
        tx_end = 1; rx_end = 1; step(); tx_end = 0; rx_end = 0;
        check_eq("done_same_lat", 32'(done), 0);
        step();
        check_eq("done_same", 32'(done), 1);

        // Residency timeout
        en = 0; step(); en = 1; step();
        repeat (TO - 1) step();
        check_eq("to_before", 32'(err), 0);
        check_eq("to_before_sub", 32'(sub_en), 1);
        step();
        check_eq("to_err", 32'(err), 1);
        check_eq("to_sub_off", 32'(sub_en), 0);
        en = 0; step();
        check_eq("to_clear", 32'(err), 0);

        // Done and timeout on the same edge: done wins
        en = 1; step();
        repeat (TO - 2) step();
        tx_end = 1; rx_end = 1; step(); tx_end = 0; rx_end = 0;
        step();
        check_eq("race_done", 32'({done, err}), 32'b10);

        // Abort during WAIT_LO, then clean re-grant
        en = 0; step(); en = 1; step();
        tx_valid = 1; tx_msg = 4'd5; tx_info = 3'b100; step();
        busy = 1; step();
        en = 0; step();
        check_eq("abort_valid", 32'(sb_valid), 0);
        check_eq("abort_sent",  32'({tx_sent, rx_sent}), 0);
        check_eq("abort_sub",   32'(sub_en), 0);
        busy = 0; step();
        check_eq("abort_no_late", 32'(tx_sent), 0);
        en = 1; step();
        check_eq("regrant_wait", 32'(sb_valid), 0);
        step();
        check_eq("regrant_valid", 32'(sb_valid), 1);
        check_eq("regrant_msg",   32'({sb_msg, sb_info}), 32'({4'd5, 3'b100}));
        busy = 1; step(); busy = 0; step();
        check_eq("regrant_sent", 32'(tx_sent), 1);
        tx_valid = 0; step();

`ifdef PHYRETRAIN_SB_STATS_EN
        en = 0; step(); en = 1; step();
        tx_end = 1; rx_end = 1; step(); tx_end = 0; rx_end = 0; step();
        tx_valid = 1; tx_msg = 4'd1; tx_info = 3'b001; step();
        for (int i = 0; i < 300; i++) begin
            busy = 1; step(); busy = 0; step(); step(); step();
        end
        tx_valid = 0; step();
        check_eq("stats_tx", 32'(tx_cnt), 255);
        check_eq("stats_rx", 32'(rx_cnt), 0);
        en = 0; step();
        check_eq("stats_clear", 32'(tx_cnt), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/phyretrain_sb_ctrl.md
Name: phyretrain_sb_ctrl

Overview:
Top-level sequencer for the PHYRETRAIN substate.
- Enables the TX and RX PHYRETRAIN sub-FSMs.
- Shares the single sideband transmit port between them using round-robin arbitration with a busy-falling-edge handshake.
- Collects both end flags and reports done to LTSM.
- Enforces a residency timeout and reports an error on expiry.
- Sits between LTSM, the TX/RX PHYRETRAIN FSMs and the SB wrapper.

Parameters:
SB_MSG_WIDTH, 4, width of encoded SB message
TIMEOUT_CYCLES, 8000, cycles in ACTIVE before timeout error
CNT_W, 24, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_phyretrain_en  in  1  LTSM enable for the substate
i_tx_valid  in  1  TX FSM has an SB message pending
i_tx_msg  in  SB_MSG_WIDTH  TX message encoding
i_tx_info  in  3  TX msg info (001 TXSELFCAL, 010 SPEEDIDLE, 100 REPAIR)
i_tx_end  in  1  TX FSM finished
i_rx_valid  in  1  RX FSM has an SB message pending
i_rx_msg  in  SB_MSG_WIDTH  RX message encoding
i_rx_info  in  3  RX msg info
i_rx_end  in  1  RX FSM finished
i_sb_busy  in  1  SB wrapper busy while serialising
o_sub_en  out  1  enable to TX/RX FSMs
o_sb_valid  out  1  message valid to SB wrapper
o_sb_msg  out  SB_MSG_WIDTH  granted message
o_sb_info  out  3  granted msg info
o_tx_sent  out  1  one-cycle pulse: TX message sent
o_rx_sent  out  1  one-cycle pulse: RX message sent
o_phyretrain_done  out  1  substate complete, to LTSM
o_timeout_err  out  1  timeout error, to LTSM

Behaviour:
Reset values: all outputs are 0. Internal state: last_grant=RX, tx_end_l=0, rx_end_l=0, counter=0.

Top FSM:
- IDLE:
  - Stays in IDLE while i_phyretrain_en=0.
  - i_phyretrain_en=1 -> ACTIVE; o_sub_en=1 from the next cycle.
- ACTIVE:
  - Counter increments every cycle.
  - i_tx_end and i_rx_end are latched sticky into tx_end_l and rx_end_l.
  - When both are set, including both arriving in the same cycle -> DONE.
  - Counter == TIMEOUT_CYCLES-1 without done -> ERROR.
  - Done condition and timeout in the same cycle -> DONE wins.
- DONE: o_phyretrain_done=1 (registered), o_sub_en stays 1.
- ERROR: o_timeout_err=1, o_sub_en=0.
- From any state, i_phyretrain_en=0 -> IDLE on the next edge:
  - counter, end latches, done and err are cleared;
  - the arbiter is aborted (o_sb_valid=0, no sent pulse).

Arbiter FSM (runs only when the top FSM is in ACTIVE or DONE):
- ARB_IDLE:
  - If only one valid is high, grant that requester.
  - If both are high, grant the requester that is not last_grant.
  - On a grant: register msg/info into o_sb_msg/o_sb_info, set o_sb_valid=1 on the next edge, update last_grant, go to WAIT_HI.
- WAIT_HI: wait for i_sb_busy=1, then -> WAIT_LO.
- WAIT_LO:
  - On i_sb_busy 1->0 (edge detected with an internal registered copy): o_sb_valid=0.
  - Pulse o_tx_sent or o_rx_sent for exactly 1 cycle.
  - -> COOL.
- COOL:
  - One cycle with no sampling of the valid inputs, so the requester can drop its valid after the sent pulse.
  - -> ARB_IDLE.
- o_sb_msg/o_sb_info are held stable while o_sb_valid=1.
- Minimum latency: 1 cycle from valid to o_sb_valid.
- Back-to-back messages: at least 1 COOL cycle between messages.
- A busy falling edge seen in WAIT_HI is ignored; only the WAIT_LO edge counts.

Optional Feature:
Macro: PHYRETRAIN_SB_STATS_EN.
- Defined:
  - Adds outputs o_tx_msg_cnt[7:0] and o_rx_msg_cnt[7:0].
  - Each increments on its sent pulse and saturates at 255.
  - Both are cleared by reset and on return to IDLE.
- Not defined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- en=1; TX valid msg=1, info=001; busy 0->1 (3 cycles) ->0 -> o_sb_valid high 1 cycle after valid, msg=1/info=001, low after busy fall, o_tx_sent single pulse.
- TX and RX valid in the same cycle after reset -> TX granted first (msg=1), RX (msg=2) granted after COOL; on the next tie RX wins.
- tx_end at cycle 10, rx_end at cycle 20 -> o_phyretrain_done=1 at cycle 22; rx_end and tx_end in the same cycle -> done 2 cycles later.
- TIMEOUT_CYCLES=16, no ends -> o_timeout_err=1 at cycle 17 after entry, o_sub_en=0; en=0 -> err cleared next cycle.
- en dropped during WAIT_LO -> o_sb_valid=0 next cycle, no sent pulse, FSMs in IDLE; re-enable -> clean new grant.
- With PHYRETRAIN_SB_STATS_EN: 300 TX messages -> o_tx_msg_cnt=255, o_rx_msg_cnt=0.
